// File: rtl/mem_access_ctrl.sv
// Multi-cycle SRAM/MMIO access sequencer producing the microsequencer ready bit.
// Decodes the LC-3 keyboard and display device registers at FE00-FE06.
module mem_access_ctrl #(
  parameter int WAIT_STATES = 4,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mio_en,
  input  logic              r_w,
  input  logic [ADDR_W-1:0] mar,
  input  logic [DATA_W-1:0] mdr_wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              r_bit,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_en,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              kbd_valid,
  input  logic [7:0]        kbd_data,
  output logic              disp_valid,
  output logic [7:0]        disp_data,
  input  logic              disp_ack
);

  localparam int CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state, next_state;
  logic [CNT_W-1:0]   cnt;
  logic               acc_write;
  logic               last_busy;
  logic               sel_kbsr, sel_kbdr, sel_dsr, sel_ddr, is_mmio;
  logic               kbsr_full, dsr_ready;
  logic [7:0]         kbdr, ddr;
  logic [DATA_W-1:0]  read_val;

  // mem_addr/mem_wdata double as the captured access, so MAR/MDR may move freely.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      acc_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state <= next_state;
      if (state == IDLE && mio_en) begin
        cnt       <= '0;
        acc_write <= r_w;
        mem_addr  <= mar;
        mem_wdata <= mdr_wdata;
      end else if (state == BUSY) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    // NOTE: defaults first so no path through this block can infer a latch.
    next_state = state;
    last_busy  = (state == BUSY) && (cnt == CNT_W'(WAIT_STATES - 1));
    unique case (state)
      IDLE:    if (mio_en) next_state = BUSY;
      BUSY:    if (last_busy) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    sel_kbsr = (mem_addr == ADDR_W'(16'hFE00));
    sel_kbdr = (mem_addr == ADDR_W'(16'hFE02));
    sel_dsr  = (mem_addr == ADDR_W'(16'hFE04));
    sel_ddr  = (mem_addr == ADDR_W'(16'hFE06));
    is_mmio  = sel_kbsr | sel_kbdr | sel_dsr | sel_ddr;
    read_val = mem_rdata;
    if (sel_kbsr)      read_val = DATA_W'({kbsr_full, 15'b0});
    else if (sel_kbdr) read_val = DATA_W'({8'b0, kbdr});
    else if (sel_dsr)  read_val = DATA_W'({dsr_ready, 15'b0});
    else if (sel_ddr)  read_val = DATA_W'({8'b0, ddr});
  end

  assign r_bit     = (state == DONE);
  assign mem_en    = (state == BUSY) && !is_mmio;
  assign mem_we    = last_busy && acc_write && !is_mmio;
  assign disp_data = ddr;

  // Later assignments win: a completing DDR write overrides disp_ack, and a new
  // keyboard char overrides the KBSR clear of a completing KBDR read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata      <= '0;
      kbsr_full  <= 1'b0;
      kbdr       <= '0;
      dsr_ready  <= 1'b1;
      ddr        <= '0;
      disp_valid <= 1'b0;
    end else begin
      disp_valid <= 1'b0;
      if (disp_ack) dsr_ready <= 1'b1;
      if (last_busy) begin
        if (acc_write) begin
          if (sel_ddr) begin
            ddr        <= mem_wdata[7:0];
            dsr_ready  <= 1'b0;
            disp_valid <= 1'b1;
          end
        end else begin
          rdata <= read_val;
          if (sel_kbdr) kbsr_full <= 1'b0;
        end
      end
      if (kbd_valid && (!kbsr_full || (last_busy && !acc_write && sel_kbdr))) begin
        kbdr      <= kbd_data;
        kbsr_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios plus randomized
// accesses scored against a register/memory-level reference model.
module tb_mem_access_ctrl;

  localparam int WS = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        mio_en, r_w, r_bit, mem_en, mem_we, kbd_valid, disp_valid, disp_ack;
  logic [15:0] mar, mdr_wdata, rdata, mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  kbd_data, disp_data;

  logic        s_mio_en, s_r_w, s_r_bit, s_mem_en, s_mem_we, s_disp_valid;
  logic [15:0] s_mar, s_mdr_wdata, s_rdata, s_mem_addr, s_mem_wdata, s_mem_rdata;
  logic [7:0]  s_disp_data;

  mem_access_ctrl #(.WAIT_STATES(WS)) dut (
    .clk(clk), .reset(reset), .mio_en(mio_en), .r_w(r_w), .mar(mar),
    .mdr_wdata(mdr_wdata), .rdata(rdata), .r_bit(r_bit), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_en(mem_en), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .kbd_valid(kbd_valid), .kbd_data(kbd_data), .disp_valid(disp_valid),
    .disp_data(disp_data), .disp_ack(disp_ack)
  );

  mem_access_ctrl #(.WAIT_STATES(1)) dut_ws1 (
    .clk(clk), .reset(reset), .mio_en(s_mio_en), .r_w(s_r_w), .mar(s_mar),
    .mdr_wdata(s_mdr_wdata), .rdata(s_rdata), .r_bit(s_r_bit), .mem_addr(s_mem_addr),
    .mem_wdata(s_mem_wdata), .mem_en(s_mem_en), .mem_we(s_mem_we), .mem_rdata(s_mem_rdata),
    .kbd_valid(1'b0), .kbd_data(8'h00), .disp_valid(s_disp_valid),
    .disp_data(s_disp_data), .disp_ack(1'b0)
  );

  // Bench-side SRAM: combinational read, written on a clock edge with mem_we.
  logic [15:0] sram [0:65535];
  always @(posedge clk) if (mem_en && mem_we) sram[mem_addr] <= mem_wdata;
  assign mem_rdata   = sram[mem_addr];
  assign s_mem_rdata = s_mem_addr ^ 16'h5A5A;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt++;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [15:0] ref_mem [0:15];
  bit          m_full, m_ready;
  logic [7:0]  m_kbdr, m_ddr;
  int          last_rb;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_full = 0; m_kbdr = 8'h00; m_ready = 1; m_ddr = 8'h00;
  endtask

  task automatic kbd_event(input logic [7:0] ch);
    @(negedge clk); kbd_valid = 1; kbd_data = ch;
    @(negedge clk); kbd_valid = 0;
    if (!m_full) begin m_kbdr = ch; m_full = 1; end
  endtask

  task automatic ack_event();
    @(negedge clk); disp_ack = 1;
    @(negedge clk); disp_ack = 0;
    m_ready = 1;
  endtask

  // One access; side events are driven so they land on the completing edge.
  task automatic access(input bit w, input logic [15:0] a, input logic [15:0] d,
                        input bit hold, input bit side_kbd, input logic [7:0] side_char,
                        input bit side_ack, input string tag);
    logic [15:0] exp_rd, got_rd;
    logic [7:0]  got_dd;
    bit          is_ram, exp_dv, addr_ok;
    int          we_n, en_n, we_cyc, rb_cyc, dv_n;
    is_ram = !(a inside {16'hFE00, 16'hFE02, 16'hFE04, 16'hFE06});
    exp_dv = w && (a == 16'hFE06);
    case (a)
      16'hFE00: exp_rd = {m_full, 15'b0};
      16'hFE02: exp_rd = {8'h00, m_kbdr};
      16'hFE04: exp_rd = {m_ready, 15'b0};
      16'hFE06: exp_rd = {8'h00, m_ddr};
      default:  exp_rd = ref_mem[a[3:0]];
    endcase
    @(negedge clk);
    mio_en = 1; r_w = w; mar = a; mdr_wdata = d;
    we_n = 0; en_n = 0; we_cyc = -1; rb_cyc = -1; dv_n = 0; addr_ok = 1;
    got_rd = 16'hxxxx; got_dd = 8'hxx;
    for (int c = 1; c <= WS + 3 && rb_cyc < 0; c++) begin
      @(negedge clk);
      if (!hold) begin
        mio_en = 0; r_w = 1'($urandom); mar = 16'($urandom); mdr_wdata = 16'($urandom);
      end
      kbd_valid = 0; disp_ack = 0;
      if (c == WS) begin kbd_valid = side_kbd; kbd_data = side_char; disp_ack = side_ack; end
      if (mem_we) begin we_n++; we_cyc = c; end
      if (mem_en) begin
        en_n++;
        if (mem_addr !== a || mem_wdata !== d) addr_ok = 0;
      end
      if (disp_valid) dv_n++;
      if (r_bit) begin rb_cyc = c; got_rd = rdata; got_dd = disp_data; last_rb = cyc_cnt; end
    end
    check({tag, " latency"}, 16'(rb_cyc), 16'(WS + 1));
    if (!w) check({tag, " rdata"}, got_rd, exp_rd);
    check({tag, " mem_we count"}, 16'(we_n), (w && is_ram) ? 16'd1 : 16'd0);
    if (w && is_ram) check({tag, " mem_we cycle"}, 16'(we_cyc), 16'(WS));
    check({tag, " mem_en count"}, 16'(en_n), is_ram ? 16'(WS) : 16'd0);
    check({tag, " captured addr/data"}, {15'b0, addr_ok}, 16'd1);
    check({tag, " disp_valid count"}, 16'(dv_n), exp_dv ? 16'd1 : 16'd0);
    if (side_ack) m_ready = 1;
    if (w) begin
      if (is_ram) ref_mem[a[3:0]] = d;
      else if (a == 16'hFE06) begin m_ddr = d[7:0]; m_ready = 0; end
    end else if (a == 16'hFE02) m_full = 0;
    if (side_kbd && !m_full) begin m_kbdr = side_char; m_full = 1; end
    if (exp_dv) check({tag, " disp_data"}, {8'h00, got_dd}, {8'h00, m_ddr});
  endtask

  initial begin
    logic [15:0] ra;
    int          sel, t1, t2, bad;
    for (int i = 0; i < 65536; i++) sram[i] = 16'h0000;
    for (int i = 0; i < 16; i++) ref_mem[i] = 16'h0000;
    model_reset();
    reset = 1; mio_en = 0; r_w = 0; mar = 0; mdr_wdata = 0;
    kbd_valid = 0; kbd_data = 0; disp_ack = 0;
    s_mio_en = 0; s_r_w = 0; s_mar = 0; s_mdr_wdata = 0;
    repeat (2) @(negedge clk);
    check("rst r_bit", {15'b0, r_bit}, 16'd0);
    check("rst rdata", rdata, 16'h0000);
    check("rst mem_en/we", {14'b0, mem_en, mem_we}, 16'd0);
    check("rst mem_addr", mem_addr, 16'h0000);
    check("rst mem_wdata", mem_wdata, 16'h0000);
    check("rst disp", {7'b0, disp_valid, disp_data}, 16'd0);
    reset = 0;

    // WAIT_STATES=1 instance: r_bit in cycle 2, captured address survives MAR change
    @(negedge clk); s_mio_en = 1; s_r_w = 1; s_mar = 16'h4000; s_mdr_wdata = 16'hBEEF;
    @(negedge clk); s_mio_en = 0; s_mar = 16'h4444; s_mdr_wdata = 16'h0000;
    check("ws1 write busy we/en/rbit", {13'b0, s_mem_we, s_mem_en, s_r_bit}, 16'b110);
    check("ws1 write addr", s_mem_addr, 16'h4000);
    check("ws1 write data", s_mem_wdata, 16'hBEEF);
    @(negedge clk);
    check("ws1 write r_bit", {15'b0, s_r_bit}, 16'd1);
    @(negedge clk); s_mio_en = 1; s_r_w = 0; s_mar = 16'h1234;
    @(negedge clk); s_mio_en = 0; s_mar = 16'h0F0F;
    check("ws1 read busy r_bit", {15'b0, s_r_bit}, 16'd0);
    @(negedge clk);
    check("ws1 read r_bit", {15'b0, s_r_bit}, 16'd1);
    check("ws1 rdata", s_rdata, 16'h1234 ^ 16'h5A5A);

    // RAM write then read back
    access(1, 16'h3000, 16'h1234, 0, 0, 0, 0, "t1 wr");
    access(0, 16'h3000, 16'h0000, 0, 0, 0, 0, "t1 rd");

    // Back-to-back reads with mio_en held high
    access(0, 16'h3000, 16'h0000, 1, 0, 0, 0, "t2 rd0");
    t1 = last_rb;
    access(0, 16'h3001, 16'h0000, 1, 0, 0, 0, "t2 rd1");
    t2 = last_rb;
    mio_en = 0;
    check("t2 r_bit spacing", 16'(t2 - t1), 16'(WS + 2));

    // Keyboard
    kbd_event(8'h41);
    kbd_event(8'h42);
    access(0, 16'hFE00, 0, 0, 0, 0, 0, "t3 kbsr full");
    access(0, 16'hFE02, 0, 0, 0, 0, 0, "t3 kbdr");
    check("t3 kbdr value", rdata, 16'h0041);
    access(0, 16'hFE00, 0, 0, 0, 0, 0, "t3 kbsr empty");
    check("t3 kbsr value", rdata, 16'h0000);
    kbd_event(8'h43);
    access(0, 16'hFE02, 0, 0, 1, 8'h44, 0, "t3 kbdr+kbd");
    access(0, 16'hFE02, 0, 0, 0, 0, 0, "t3 kbdr new");
    check("t3 set-wins char", rdata, 16'h0044);

    // Display
    access(1, 16'hFE06, 16'h0058, 0, 0, 0, 0, "t4 ddr wr");
    check("t4 disp_data", {8'h00, disp_data}, 16'h0058);
    access(0, 16'hFE04, 0, 0, 0, 0, 0, "t4 dsr busy");
    check("t4 dsr value", rdata, 16'h0000);
    ack_event();
    access(0, 16'hFE04, 0, 0, 0, 0, 0, "t4 dsr ready");
    check("t4 dsr ready value", rdata, 16'h8000);
    access(1, 16'hFE06, 16'h0077, 0, 0, 0, 1, "t4 ddr wr+ack");
    access(0, 16'hFE04, 0, 0, 0, 0, 0, "t4 write-wins");
    access(1, 16'hFE00, 16'hFFFF, 0, 0, 0, 0, "t4 kbsr wr ignored");
    access(0, 16'hFE06, 0, 0, 0, 0, 0, "t4 ddr rd");

    // Reset during BUSY of a write
    @(negedge clk); mio_en = 1; r_w = 1; mar = 16'h3005; mdr_wdata = 16'hDEAD;
    @(negedge clk); mio_en = 0;
    @(negedge clk);
    reset = 1; #1;
    check("t5 rst mem_en/we/rbit", {13'b0, mem_en, mem_we, r_bit}, 16'd0);
    check("t5 rst mem_addr", mem_addr, 16'h0000);
    check("t5 rst rdata", rdata, 16'h0000);
    bad = 0;
    @(negedge clk);
    reset = 0;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (mem_we || r_bit || mem_en) bad++;
    end
    check("t5 quiet after reset", 16'(bad), 16'd0);
    access(0, 16'h3005, 0, 0, 0, 0, 0, "t5 lost write");
    access(0, 16'hFE04, 0, 0, 0, 0, 0, "t5 dsr reset");

    // Randomized accesses against the model
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 7);
      case (sel)
        0: ra = 16'hFE00;
        1: ra = 16'hFE02;
        2: ra = 16'hFE04;
        3: ra = 16'hFE06;
        default: ra = 16'h3000 + 16'($urandom_range(0, 15));
      endcase
      if ($urandom_range(0, 3) == 0) kbd_event(8'($urandom));
      if ($urandom_range(0, 3) == 0) ack_event();
      access(1'($urandom_range(0, 1)), ra, 16'($urandom), 0,
             1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
